mem_port_arbiter: RTL and testbench

//  Shares one backing memory port between the fetch (imem) and memory-stage (dmem) requesters.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 22 ++
 rtl/mem_arb_grant.sv | 38 +++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter: request/response bundles,
// ownership and FSM state encodings.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } mem_req_t;

    typedef struct packed {
        mem_req_t req;
        logic     req_valid;
    } MemoryIn;

    typedef struct packed {
        logic              req_ready;
        logic [DATA_W-1:0] res;
        logic              res_valid;
    } MemoryOut;

    typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} ArbOwner;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} ArbState;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three memory ports around the arbiter: two upstream requesters
// and the shared backing memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    MemoryIn  imem_in;
    MemoryOut imem_out;
    MemoryIn  dmem_in;
    MemoryOut dmem_out;
    MemoryIn  mem_in;
    MemoryOut mem_out;

    modport slave (
        input  imem_in, dmem_in, mem_out,
        output imem_out, dmem_out, mem_in
    );

    modport master (
        output imem_in, dmem_in, mem_out,
        input  imem_out, dmem_out, mem_in
    );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requesters, with a dmem streak limit so
// a busy data stage cannot starve instruction fetch.
module mem_arb_grant #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic imem_valid,
    input  logic dmem_valid,
    input  logic idle,
    output logic grant_i,
    output logic grant_d
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0] streak_q, streak_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_d  = idle && dmem_valid && (!imem_valid || (streak_q < STREAK_MAX));
        grant_i  = idle && imem_valid && !grant_d;
        streak_d = streak_q;
        if (grant_i) begin
            streak_d = '0;
        end else if (grant_d) begin
            // Streak only grows while fetch is actually being held off.
            if (!imem_valid)                  streak_d = '0;
            else if (streak_q != STREAK_MAX)  streak_d = streak_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= '0;
        else        streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing memory port between fetch and data requesters: one
// buffered transaction in flight, response routed back to its owner.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mem_port_arbiter_if.slave         port,
    output ArbOwner                   owner,
    output logic                      err_spurious
);
    ArbState  state_q, state_d;
    ArbOwner  owner_q, owner_d;
    mem_req_t buf_q,   buf_d;
    logic     err_q,   err_d;
    logic     grant_i, grant_d;

    mem_arb_grant #(.MAX_DSTREAK(MAX_DSTREAK)) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_valid (port.imem_in.req_valid),
        .dmem_valid (port.dmem_in.req_valid),
        .idle       (state_q == ARB_IDLE),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        buf_d         = buf_q;
        err_d         = err_q;
        port.imem_out = '0;
        port.dmem_out = '0;
        port.mem_in   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                port.imem_out.req_ready = grant_i;
                port.dmem_out.req_ready = grant_d;
                if (grant_d) begin
                    buf_d   = port.dmem_in.req;
                    owner_d = OWN_DMEM;
                    state_d = ARB_ISSUE;
                end else if (grant_i) begin
                    buf_d   = port.imem_in.req;
                    owner_d = OWN_IMEM;
                    state_d = ARB_ISSUE;
                end
                if (port.mem_out.res_valid) err_d = 1'b1;
            end
            ARB_ISSUE: begin
                port.mem_in.req       = buf_q;
                port.mem_in.req_valid = 1'b1;
                if (port.mem_out.req_ready) state_d = ARB_WAIT;
                // A response cannot belong to a request the memory is only now accepting.
                if (port.mem_out.res_valid) err_d = 1'b1;
            end
            ARB_WAIT: begin
                if (port.mem_out.res_valid) begin
                    if (owner_q == OWN_IMEM) begin
                        port.imem_out.res       = port.mem_out.res;
                        port.imem_out.res_valid = 1'b1;
                    end else if (owner_q == OWN_DMEM) begin
                        port.dmem_out.res       = port.mem_out.res;
                        port.dmem_out.res_valid = 1'b1;
                    end
                    owner_d = OWN_NONE;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // NOTE: the request buffer is reset too, so a reset mid-transaction leaves no stale request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign owner        = owner_q;
    assign err_spurious = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model of the arbitration and response-routing rules.
import mem_port_arbiter_pkg::*;

module tb_mem_port_arbiter;
    localparam int MAX_D = 4;

    logic    clk = 1'b0;
    logic    rst_n;
    ArbOwner owner;
    logic    err_spurious;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_DSTREAK(MAX_D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port         (bus.slave),
        .owner        (owner),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: where the single outstanding transaction is in its life.
    // 0 = nothing outstanding, 1 = waiting for memory to accept, 2 = waiting for data.
    int       m_phase;
    int       m_owner;   // 0 none, 1 imem, 2 dmem
    mem_req_t m_req;
    int       m_streak;
    bit       m_err;
    int       dut_grant; // 0 none, 1 imem, 2 dmem, as observed this cycle

    function automatic bit model_dmem_wins(input bit iv, input bit dv);
        return dv && (!iv || m_streak < MAX_D);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_req = '0; m_streak = 0; m_err = 0;
    endtask

    // Compare all DUT outputs against the model for the current cycle's inputs.
    task automatic check_cycle();
        bit iv, dv, dw, iw, rv;
        #1;
        iv = bus.imem_in.req_valid;
        dv = bus.dmem_in.req_valid;
        rv = bus.mem_out.res_valid;
        dw = (m_phase == 0) && model_dmem_wins(iv, dv);
        iw = (m_phase == 0) && iv && !dw;
        check("imem_ready", 128'(bus.imem_out.req_ready), 128'(iw));
        check("dmem_ready", 128'(bus.dmem_out.req_ready), 128'(dw));
        check("imem_rvalid", 128'(bus.imem_out.res_valid), 128'(m_phase == 2 && rv && m_owner == 1));
        check("dmem_rvalid", 128'(bus.dmem_out.res_valid), 128'(m_phase == 2 && rv && m_owner == 2));
        if (m_phase == 2 && rv && m_owner == 1) check("imem_res", 128'(bus.imem_out.res), 128'(bus.mem_out.res));
        if (m_phase == 2 && rv && m_owner == 2) check("dmem_res", 128'(bus.dmem_out.res), 128'(bus.mem_out.res));
        check("mem_valid", 128'(bus.mem_in.req_valid), 128'(m_phase == 1));
        if (m_phase == 1) check("mem_req", 128'(bus.mem_in.req), 128'(m_req));
        check("owner", 128'(owner), 128'(m_owner));
        check("err", 128'(err_spurious), 128'(m_err));
        dut_grant = bus.imem_out.req_ready ? 1 : (bus.dmem_out.req_ready ? 2 : 0);
    endtask

    // Advance one clock and move the model by the same cycle's rules.
    task automatic advance();
        bit iv, dv, dw, rv, rdy;
        mem_req_t ireq, dreq;
        iv = bus.imem_in.req_valid;  ireq = bus.imem_in.req;
        dv = bus.dmem_in.req_valid;  dreq = bus.dmem_in.req;
        rv = bus.mem_out.res_valid;  rdy  = bus.mem_out.req_ready;
        @(posedge clk);
        case (m_phase)
            0: begin
                if (rv) m_err = 1;
                dw = model_dmem_wins(iv, dv);
                if (dw) begin
                    m_phase = 1; m_owner = 2; m_req = dreq;
                    m_streak = iv ? ((m_streak + 1 > MAX_D) ? MAX_D : m_streak + 1) : 0;
                end else if (iv) begin
                    m_phase = 1; m_owner = 1; m_req = ireq; m_streak = 0;
                end
            end
            1: begin
                if (rv)  m_err = 1;
                if (rdy) m_phase = 2;
            end
            default: begin
                if (rv) begin m_phase = 0; m_owner = 0; end
            end
        endcase
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_in = '0;
        bus.dmem_in = '0;
        bus.mem_out = '0;
    endtask

    // Asynchronous reset: outputs must go idle without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        check("rst_imem_out", 128'(bus.imem_out), 128'(0));
        check("rst_dmem_out", 128'(bus.dmem_out), 128'(0));
        check("rst_mem_valid", 128'(bus.mem_in.req_valid), 128'(0));
        check("rst_owner", 128'(owner), 128'(OWN_NONE));
        check("rst_err", 128'(err_spurious), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic mem_req_t rand_req();
        mem_req_t r;
        r.addr  = $urandom;
        r.wdata = $urandom;
        r.we    = 1'($urandom);
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_req_t cap;
        int       k;
        rst_n = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            check_cycle();
            advance();
        end

        // Single imem read.
        bus.imem_in.req = '{addr: 32'h100, wdata: 32'h0, we: 1'b0};
        bus.imem_in.req_valid = 1'b1;
        check_cycle();
        check("t2_grant", 128'(bus.imem_out.req_ready), 128'(1));
        advance();
        bus.imem_in = '0;
        bus.mem_out.req_ready = 1'b1;
        check_cycle();
        check("t2_addr", 128'(bus.mem_in.req.addr), 128'(32'h100));
        check("t2_mvalid", 128'(bus.mem_in.req_valid), 128'(1));
        advance();
        bus.mem_out = '{req_ready: 1'b0, res: 32'hDEADBEEF, res_valid: 1'b1};
        check_cycle();
        check("t2_res", 128'(bus.imem_out.res), 128'(32'hDEADBEEF));
        check("t2_rvalid", 128'(bus.imem_out.res_valid), 128'(1));
        check("t2_dvalid", 128'(bus.dmem_out.res_valid), 128'(0));
        advance();
        bus.mem_out = '0;
        check_cycle();
        check("t2_owner_idle", 128'(owner), 128'(OWN_NONE));
        advance();

        // Fairness: both requesters always valid, memory answers promptly.
        do_reset();
        bus.imem_in = '{req: rand_req(), req_valid: 1'b1};
        bus.dmem_in = '{req: rand_req(), req_valid: 1'b1};
        k = 0;
        for (int i = 0; i < 36; i++) begin
            bus.mem_out = '{req_ready: 1'b1, res: $urandom, res_valid: (m_phase == 2)};
            check_cycle();
            if (dut_grant != 0) begin
                check($sformatf("t3_grant%0d", k), 128'(dut_grant), 128'((k % 5 == 4) ? 1 : 2));
                k++;
            end
            advance();
            if (dut_grant == 1) bus.imem_in.req = rand_req();
            if (dut_grant == 2) bus.dmem_in.req = rand_req();
        end
        check("t3_grant_count", 128'(k), 128'(12));
        clear_inputs();

        // Memory stalls in ARB_ISSUE while requesters keep pushing new requests.
        do_reset();
        cap = rand_req();
        bus.imem_in = '{req: cap, req_valid: 1'b1};
        check_cycle();
        advance();
        for (int i = 0; i < 5; i++) begin
            bus.imem_in = '{req: rand_req(), req_valid: 1'b1};
            bus.dmem_in = '{req: rand_req(), req_valid: 1'b1};
            check_cycle();
            check("t4_mvalid", 128'(bus.mem_in.req_valid), 128'(1));
            check("t4_stable", 128'(bus.mem_in.req), 128'(cap));
            check("t4_no_ready", 128'({bus.imem_out.req_ready, bus.dmem_out.req_ready}), 128'(0));
            advance();
        end
        clear_inputs();

        // Spurious response in ARB_IDLE is sticky until reset.
        do_reset();
        bus.mem_out = '{req_ready: 1'b0, res: 32'h1234, res_valid: 1'b1};
        check_cycle();
        check("t5_no_fwd", 128'({bus.imem_out.res_valid, bus.dmem_out.res_valid}), 128'(0));
        advance();
        bus.mem_out = '0;
        for (int i = 0; i < 5; i++) begin
            check_cycle();
            check("t5_sticky", 128'(err_spurious), 128'(1));
            advance();
        end
        do_reset();

        // Reset during the ARB_WAIT of a dmem store; late response is spurious.
        bus.dmem_in = '{req: '{addr: 32'h40, wdata: 32'hCAFE, we: 1'b1}, req_valid: 1'b1};
        check_cycle();
        advance();
        bus.dmem_in = '0;
        bus.mem_out.req_ready = 1'b1;
        check_cycle();
        advance();
        bus.mem_out = '0;
        check_cycle();
        check("t6_owner_wait", 128'(owner), 128'(OWN_DMEM));
        do_reset();
        bus.mem_out = '{req_ready: 1'b0, res: 32'h5555, res_valid: 1'b1};
        check_cycle();
        check("t6_no_fwd", 128'(bus.dmem_out.res_valid), 128'(0));
        advance();
        bus.mem_out = '0;
        check_cycle();
        check("t6_err", 128'(err_spurious), 128'(1));
        advance();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            if (!bus.imem_in.req_valid) bus.imem_in = '{req: rand_req(), req_valid: ($urandom_range(2) != 0)};
            else if ($urandom_range(7) == 0) bus.imem_in.req_valid = 1'b0;
            if (!bus.dmem_in.req_valid) bus.dmem_in = '{req: rand_req(), req_valid: ($urandom_range(2) != 0)};
            else if ($urandom_range(7) == 0) bus.dmem_in.req_valid = 1'b0;
            bus.mem_out.req_ready = 1'($urandom);
            bus.mem_out.res       = $urandom;
            bus.mem_out.res_valid = (m_phase == 2) ? ($urandom_range(9) < 6) : ($urandom_range(99) < 3);
            check_cycle();
            advance();
            if (dut_grant == 1) bus.imem_in.req_valid = 1'b0;
            if (dut_grant == 2) bus.dmem_in.req_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
